// File: rtl/rpn_stack_ctrl.sv
// Purpose: RPN token sequencer driving an external 32-deep LIFO; tracks depth, runs binary ALU ops, flags over/underflow.
// Latency: PUSH/CLR/error 1 cycle after accept, POP result at t+2, ALU result at t+3; back in IDLE one cycle later.
// Backpressure: tok_ready is high only in IDLE (and not in the first cycle after reset), so one token is in flight at a time.
module rpn_stack_ctrl #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 31,
  parameter int DEPTH_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tok_valid,
  output logic               tok_ready,
  input  logic [2:0]         tok_op,
  input  logic [WIDTH-1:0]   tok_data,
  output logic               stk_push,
  output logic               stk_pop,
  output logic               stk_clr,
  output logic [WIDTH-1:0]   stk_wdata,
  input  logic [WIDTH-1:0]   stk_rdata,
  output logic               res_valid,
  output logic [WIDTH-1:0]   res_data,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [DEPTH_W-1:0] depth
);

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_POP  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_OVER  = 2'b10;

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] DEPTH_TWO = DEPTH_W'(2);

  typedef enum logic [2:0] {
    S_IDLE, S_PUSH, S_POP_B, S_POP_A, S_EXEC, S_OUT, S_CLR, S_ERR
  } state_t;

  state_t             state, nxt;
  logic               up;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   lit_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   res_q;
  logic [1:0]         code_q;
  logic [1:0]         code_n;
  logic [WIDTH-1:0]   alu_r;
  logic               acc;

  // ready is held low for the first cycle after reset so no output is high during reset
  assign tok_ready = up && (state == S_IDLE);
  assign acc       = tok_valid && tok_ready;

  // ALU: A is the deeper operand arriving now from the stack, B was latched in POP_A
  always_comb begin
    alu_r = '0;
    case (op_q)
      OP_ADD:  alu_r = stk_rdata + b_q;
      OP_SUB:  alu_r = stk_rdata - b_q;
      OP_AND:  alu_r = stk_rdata & b_q;
      OP_OR:   alu_r = stk_rdata | b_q;
      OP_XOR:  alu_r = stk_rdata ^ b_q;
      default: alu_r = '0;
    endcase
  end

  // next state, including the legality check made at token acceptance
  always_comb begin
    nxt    = state;
    code_n = 2'b00;
    case (state)
      S_IDLE: begin
        if (acc) begin
          case (tok_op)
            OP_PUSH: begin
              if (depth == DEPTH_MAX) begin
                nxt    = S_ERR;
                code_n = ERR_OVER;
              end else begin
                nxt = S_PUSH;
              end
            end
            OP_POP: begin
              if (depth == '0) begin
                nxt    = S_ERR;
                code_n = ERR_UNDER;
              end else begin
                nxt = S_POP_B;
              end
            end
            OP_CLR: nxt = S_CLR;
            default: begin
              if (depth < DEPTH_TWO) begin
                nxt    = S_ERR;
                code_n = ERR_UNDER;
              end else begin
                nxt = S_POP_B;
              end
            end
          endcase
        end
      end
      S_POP_B: nxt = (op_q == OP_POP) ? S_OUT : S_POP_A;
      S_POP_A: nxt = S_EXEC;
      default: nxt = S_IDLE;
    endcase
  end

  // state register plus latched token fields
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      up     <= 1'b0;
      op_q   <= '0;
      lit_q  <= '0;
      code_q <= '0;
    end else begin
      state <= nxt;
      up    <= 1'b1;
      if (acc) begin
        op_q   <= tok_op;
        lit_q  <= tok_data;
        code_q <= code_n;
      end
    end
  end

  // depth tracking and operand/result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      depth <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else begin
      case (state)
        S_PUSH:  depth <= depth + DEPTH_ONE;
        S_POP_B: depth <= depth - DEPTH_ONE;
        S_POP_A: begin
          depth <= depth - DEPTH_ONE;
          b_q   <= stk_rdata;
        end
        S_EXEC: begin
          depth <= depth + DEPTH_ONE;
          res_q <= alu_r;
        end
        S_OUT:   res_q <= stk_rdata;
        S_CLR:   depth <= '0;
        default: ;
      endcase
    end
  end

  // stack controls and result/error outputs decode from state only
  always_comb begin
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_clr   = 1'b0;
    stk_wdata = '0;
    res_valid = 1'b0;
    res_data  = res_q;
    err       = 1'b0;
    err_code  = 2'b00;
    case (state)
      S_PUSH: begin
        stk_push  = 1'b1;
        stk_wdata = lit_q;
      end
      S_POP_B, S_POP_A: stk_pop = 1'b1;
      S_EXEC: begin
        stk_push  = 1'b1;
        stk_wdata = alu_r;
        res_valid = 1'b1;
        res_data  = alu_r;
      end
      S_OUT: begin
        res_valid = 1'b1;
        res_data  = stk_rdata;
      end
      S_CLR: stk_clr = 1'b1;
      S_ERR: begin
        err      = 1'b1;
        err_code = code_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Purpose: randomized and directed bench for rpn_stack_ctrl with a queue-based RPN reference model.
// Latency: checks every pulse position relative to the accepting clock edge.
// Backpressure: waits on tok_ready with a bounded cycle budget before each token.
module tb_rpn_stack_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tok_valid = 1'b0;
  logic        tok_ready;
  logic [2:0]  tok_op = 3'd0;
  logic [31:0] tok_data = 32'd0;
  logic        stk_push, stk_pop, stk_clr;
  logic [31:0] stk_wdata;
  logic [31:0] stk_rdata;
  logic        res_valid;
  logic [31:0] res_data;
  logic        err;
  logic [1:0]  err_code;
  logic [4:0]  depth;

  int checks = 0;
  int failures = 0;

  logic [31:0] ref_q[$];   // reference model: abstract RPN stack contents
  logic [31:0] mem_q[$];   // behavioural LIFO attached to the DUT
  logic [31:0] last_res = 32'd0;

  rpn_stack_ctrl #(.WIDTH(32), .DEPTH(31), .DEPTH_W(5)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_op(tok_op), .tok_data(tok_data),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_clr(stk_clr),
    .stk_wdata(stk_wdata), .stk_rdata(stk_rdata),
    .res_valid(res_valid), .res_data(res_data),
    .err(err), .err_code(err_code), .depth(depth)
  );

  always #5 clk = ~clk;

  // 32x32 LIFO with registered pop output and sync clear
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q.delete();
      stk_rdata <= 32'd0;
    end else if (stk_clr) begin
      mem_q.delete();
    end else if (stk_push) begin
      mem_q.push_back(stk_wdata);
    end else if (stk_pop) begin
      if (mem_q.size() > 0) stk_rdata <= mem_q.pop_back();
      else stk_rdata <= 32'd0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!tok_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!tok_ready) chk("ready_timeout", 32'(tok_ready), 32'd1);
  endtask

  // issue one token, observe the whole transaction, compare against the model
  task automatic run_tok(input logic [2:0] op, input logic [31:0] data);
    int dep = ref_q.size();
    logic [1:0]  e_code = 2'b00;
    logic [31:0] a, b, r = 32'd0;
    int e_push = 0, e_pop = 0, e_clr = 0, e_res = 0, e_done = 2, e_resk = 0, e_pushk = 0;
    int npush = 0, npop = 0, nclr = 0, nres = 0, nerr = 0, viol = 0;
    int push_k = 0, res_k = 0, err_k = 0, done_k = 0;
    logic [31:0] wdat = 32'd0, rval = 32'd0;
    logic [1:0]  code = 2'b00;

    if (op == 3'd0 && dep == 31) e_code = 2'b10;
    else if (op >= 3'd1 && op <= 3'd5 && dep < 2) e_code = 2'b01;
    else if (op == 3'd6 && dep == 0) e_code = 2'b01;

    if (e_code == 2'b00) begin
      case (op)
        3'd0: begin e_push = 1; e_pushk = 1; r = data; ref_q.push_back(data); end
        3'd6: begin e_pop = 1; e_res = 1; e_resk = 2; e_done = 3; r = ref_q.pop_back(); end
        3'd7: begin e_clr = 1; ref_q.delete(); end
        default: begin
          b = ref_q.pop_back();
          a = ref_q.pop_back();
          case (op)
            3'd1: r = a + b;
            3'd2: r = a - b;
            3'd3: r = a & b;
            3'd4: r = a | b;
            default: r = a ^ b;
          endcase
          ref_q.push_back(r);
          e_push = 1; e_pushk = 3; e_pop = 2; e_res = 1; e_resk = 3; e_done = 4;
        end
      endcase
    end

    wait_ready();
    tok_valid = 1'b1;
    tok_op    = op;
    tok_data  = data;
    @(posedge clk);
    #1;
    tok_valid = 1'b0;
    tok_data  = $urandom;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (stk_push) begin npush++; push_k = k; wdat = stk_wdata; end
      if (stk_pop) npop++;
      if (stk_clr) nclr++;
      if (res_valid) begin nres++; res_k = k; rval = res_data; end
      if (err) begin nerr++; err_k = k; code = err_code; end
      if ((stk_push && stk_pop) || (!stk_push && stk_wdata != 32'd0)) viol++;
      if (tok_ready) begin done_k = k; break; end
    end

    chk("err_cnt", 32'(nerr), (e_code != 2'b00) ? 32'd1 : 32'd0);
    if (e_code != 2'b00) begin
      chk("err_code", 32'(code), 32'(e_code));
      chk("err_lat", 32'(err_k), 32'd1);
    end
    chk("push_cnt", 32'(npush), 32'(e_push));
    chk("pop_cnt", 32'(npop), 32'(e_pop));
    chk("clr_cnt", 32'(nclr), 32'(e_clr));
    chk("res_cnt", 32'(nres), 32'(e_res));
    if (e_push != 0) begin
      chk("push_lat", 32'(push_k), 32'(e_pushk));
      chk("push_data", wdat, r);
    end
    if (e_res != 0) begin
      chk("res_lat", 32'(res_k), 32'(e_resk));
      chk("res_data", rval, r);
      last_res = r;
    end
    chk("res_hold", res_data, last_res);
    chk("done_lat", 32'(done_k), 32'(e_done));
    chk("depth", 32'(depth), 32'(ref_q.size()));
    chk("invariant", 32'(viol), 32'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    ref_q.delete();
    last_res = 32'd0;
    #1;
    chk("rst_push", 32'(stk_push), 32'd0);
    chk("rst_pop", 32'(stk_pop), 32'd0);
    chk("rst_ready", 32'(tok_ready), 32'd0);
    chk("rst_res", res_data, 32'd0);
    chk("rst_resv", 32'(res_valid), 32'd0);
    chk("rst_err", {29'd0, err, err_code}, 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_ready();
    chk("ready_after_rst", 32'(tok_ready), 32'd1);
  endtask

  initial begin
    int r;
    logic [2:0] op;
    apply_reset();

    // 5 - 3 = 2, then 3 - 5 wraps
    run_tok(3'd0, 32'd5);
    run_tok(3'd0, 32'd3);
    run_tok(3'd2, 32'd0);
    run_tok(3'd7, 32'd0);
    run_tok(3'd0, 32'd3);
    run_tok(3'd0, 32'd5);
    run_tok(3'd2, 32'd0);
    chk("wrap_value", last_res, 32'hFFFF_FFFE);
    // ADD at depth 1 underflows
    run_tok(3'd1, 32'd0);
    // fill to 31, then overflow
    run_tok(3'd7, 32'd0);
    for (int i = 0; i < 31; i++) run_tok(3'd0, $urandom);
    run_tok(3'd0, 32'd7);
    chk("full_depth", 32'(depth), 32'd31);
    // push/pop then pop-underflow
    run_tok(3'd7, 32'd0);
    run_tok(3'd0, 32'h0000_AAAA);
    run_tok(3'd6, 32'd0);
    run_tok(3'd6, 32'd0);

    // reset in the middle of an ADD (during POP_A)
    run_tok(3'd0, 32'd1);
    run_tok(3'd0, 32'd2);
    wait_ready();
    tok_valid = 1'b1;
    tok_op    = 3'd1;
    @(posedge clk);
    #1;
    tok_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("popa_active", 32'(stk_pop), 32'd1);
    apply_reset();

    // CLR at depth 4
    for (int i = 0; i < 4; i++) run_tok(3'd0, $urandom);
    run_tok(3'd7, 32'd0);

    // random mix, then a push-heavy phase to reach overflow
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45) op = 3'd0;
      else if (r < 82) op = 3'($urandom_range(1, 5));
      else if (r < 95) op = 3'd6;
      else op = 3'd7;
      run_tok(op, $urandom);
    end
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 99);
      if (r < 85) op = 3'd0;
      else op = 3'($urandom_range(1, 6));
      run_tok(op, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
